// File: rtl/dram_write_buffer.sv
// rtl/dram_write_buffer.sv - posted-write buffer between CPU Wishbone and the DRAM controller
// Writes are acked into a FIFO and drained in order; reads wait for the FIFO to empty.
module dram_write_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic [31:0] s_data_o,
    output logic        s_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    output logic        buf_empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_RESP} m_state_t;

    m_state_t       state_q;
    logic [63:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           rd_pend_q, rd_drop_q;
    logic [31:0]    rd_addr_q;
    logic           s_ack_q, m_cyc_q, m_stb_q, m_we_q, buf_empty_q;
    logic [31:0]    m_addr_q, m_data_q, s_data_q;

    logic s_req, full, push, pop, rd_req, rd_abort, resp_ack;

    always_comb begin
        s_req    = s_cyc_i & s_stb_i & ~s_ack_q;
        full     = (count_q == FULL_CNT);
        pop      = (state_q == M_WRITE) & m_ack_i;
        // a pop on the same edge frees the slot, so a full FIFO can still accept
        push     = s_req & s_we_i & ~rd_pend_q & (~full | pop);
        rd_req   = s_req & ~s_we_i & ~rd_pend_q;
        rd_abort = rd_pend_q & ~s_cyc_i;
        resp_ack = (state_q == M_RESP) & s_cyc_i & ~rd_drop_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_addr_i, s_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= M_IDLE;
            m_cyc_q     <= 1'b0;
            m_stb_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            s_data_q    <= '0;
            s_ack_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_drop_q   <= 1'b0;
            rd_addr_q   <= '0;
            buf_empty_q <= 1'b1;
        end else begin
            s_ack_q     <= push | resp_ack;
            buf_empty_q <= (count_q == '0) && (state_q == M_IDLE);
            if (rd_req) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= s_addr_i;
            end
            // an abort before the read is issued simply forgets it
            if (rd_abort && (state_q == M_IDLE || state_q == M_WRITE)) begin
                rd_pend_q <= 1'b0;
            end
            case (state_q)
                M_IDLE: begin
                    if (count_q != '0) begin
                        state_q              <= M_WRITE;
                        m_cyc_q              <= 1'b1;
                        m_stb_q              <= 1'b1;
                        m_we_q               <= 1'b1;
                        {m_addr_q, m_data_q} <= mem_q[rd_ptr_q];
                    end else if (rd_pend_q && s_cyc_i) begin
                        state_q   <= M_READ;
                        m_cyc_q   <= 1'b1;
                        m_stb_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= rd_addr_q;
                        rd_drop_q <= 1'b0;
                    end
                end
                M_WRITE: begin
                    if (m_ack_i) begin
                        state_q <= M_IDLE;
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                    end
                end
                M_READ: begin
                    if (rd_abort) rd_drop_q <= 1'b1;
                    if (m_ack_i) begin
                        if (!rd_drop_q && s_cyc_i) s_data_q <= m_data_i;
                        state_q <= M_RESP;
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                    end
                end
                M_RESP: begin
                    rd_pend_q <= 1'b0;
                    rd_drop_q <= 1'b0;
                    state_q   <= M_IDLE;
                end
                default: state_q <= M_IDLE;
            endcase
        end
    end

    assign s_data_o    = s_data_q;
    assign s_ack_o     = s_ack_q;
    assign m_cyc_o     = m_cyc_q;
    assign m_stb_o     = m_stb_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_data_o    = m_data_q;
    assign buf_empty_o = buf_empty_q;
endmodule

// File: tb/tb_dram_write_buffer.sv
// tb/tb_dram_write_buffer.sv - self-checking bench for dram_write_buffer
// Per-cycle vector table for single write and read-after-write, directed sequences for the rest.
module tb_dram_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [31:0] s_addr_i, s_data_i, s_data_o;
    logic        s_ack_o, m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_addr_o, m_data_o, m_data_i;
    logic        m_ack_i, buf_empty_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dram_write_buffer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_data_o(s_data_o), .s_ack_o(s_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_data_i(m_data_i), .m_ack_i(m_ack_i),
        .buf_empty_o(buf_empty_o)
    );

    typedef struct {
        logic        rst, cyc, stb, we;
        logic [31:0] addr, wdata, mdata;
        logic        mack;
        logic        eack, ecyc, ewe, eempty;
        logic [31:0] eaddr, edata, esdata;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_addr_i = '0; s_data_i = '0; m_data_i = '0; m_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for m_cyc_o with a cycle budget; returns 1 when seen.
    task automatic wait_mcyc(input int budget, output logic seen);
        seen = m_cyc_o;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = m_cyc_o;
        end
    endtask

    initial begin
        logic        seen;
        logic        bad;
        logic [31:0] sd_hold;
        idle_inputs();

        //            rst cyc stb we  addr        wdata         mdata         mack  eack ecyc ewe emp eaddr       edata         esdata
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b1,32'h0,     32'h0,        32'h0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,32'h100,   32'hDEADBEEF, 32'h0,        1'b0, 1'b1,1'b0,1'b0,1'b1,32'h0,     32'h0,        32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b1,1'b0,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b1,1'b0,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b1,1'b0,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b1, 1'b0,1'b0,1'b1,1'b0,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b1,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,32'h200,   32'h12345678, 32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,32'h100,   32'hDEADBEEF, 32'h0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b1,1'b0,32'h200,   32'h12345678, 32'h0};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b1,1'b0,32'h200,   32'h12345678, 32'h0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h0,        1'b1, 1'b0,1'b0,1'b1,1'b0,32'h200,   32'h12345678, 32'h0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h0,        1'b0, 1'b0,1'b1,1'b0,1'b1,32'h200,   32'h12345678, 32'h0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h12345678, 1'b1, 1'b0,1'b0,1'b0,1'b0,32'h200,   32'h12345678, 32'h12345678};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,32'h200,   32'h0,        32'h0,        1'b0, 1'b1,1'b0,1'b0,1'b0,32'h200,   32'h12345678, 32'h12345678};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b1,32'h200,   32'h12345678, 32'h12345678};

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst; s_cyc_i = vecs[i].cyc; s_stb_i = vecs[i].stb; s_we_i = vecs[i].we;
            s_addr_i = vecs[i].addr; s_data_i = vecs[i].wdata;
            m_data_i = vecs[i].mdata; m_ack_i = vecs[i].mack;
            tick();
            check($sformatf("v%0d s_ack", i),  32'(s_ack_o),     32'(vecs[i].eack));
            check($sformatf("v%0d m_cyc", i),  32'(m_cyc_o),     32'(vecs[i].ecyc));
            check($sformatf("v%0d m_stb", i),  32'(m_stb_o),     32'(vecs[i].ecyc));
            check($sformatf("v%0d m_we", i),   32'(m_we_o),      32'(vecs[i].ewe));
            check($sformatf("v%0d empty", i),  32'(buf_empty_o), 32'(vecs[i].eempty));
            check($sformatf("v%0d m_addr", i), m_addr_o,         vecs[i].eaddr);
            check($sformatf("v%0d m_data", i), m_data_o,         vecs[i].edata);
            check($sformatf("v%0d s_data", i), s_data_o,         vecs[i].esdata);
        end

        // Fill to full with 9 writes, the last one stalls while m_ack_i stays low.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
            s_addr_i = 32'h1000 + 32'(4 * i); s_data_i = 32'hA000_0000 + 32'(i);
            seen = 1'b0;
            for (int n = 0; n < 12 && !seen; n++) begin
                tick();
                seen = s_ack_o;
            end
            check($sformatf("fill ack %0d", i), 32'(seen), (i < 8) ? 32'd1 : 32'd0);
        end
        check("full head addr", m_addr_o, 32'h1000);
        check("full head cyc", 32'(m_cyc_o), 32'd1);
        // Pop and stalled push on the same edge.
        m_ack_i = 1'b1;
        tick();
        m_ack_i = 1'b0;
        check("9th ack after pop", 32'(s_ack_o), 32'd1);
        check("cyc drop after pop", 32'(m_cyc_o), 32'd0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        for (int k = 1; k < 9; k++) begin
            wait_mcyc(10, seen);
            check($sformatf("drain %0d seen", k), 32'(seen), 32'd1);
            check($sformatf("drain %0d addr", k), m_addr_o, 32'h1000 + 32'(4 * k));
            check($sformatf("drain %0d data", k), m_data_o, 32'hA000_0000 + 32'(k));
            m_ack_i = 1'b1;
            tick();
            m_ack_i = 1'b0;
        end
        tick();
        tick();
        check("drained empty", 32'(buf_empty_o), 32'd1);
        check("drained cyc", 32'(m_cyc_o), 32'd0);

        // Reset in the middle of a master write discards buffered entries.
        do_reset();
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h300; s_data_i = 32'h1;
        tick();
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        tick();
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_addr_i = 32'h304; s_data_i = 32'h2;
        tick();
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        check("pre-reset write cyc", 32'(m_cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset cyc", 32'(m_cyc_o), 32'd0);
        check("reset empty", 32'(buf_empty_o), 32'd1);
        bad = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (m_cyc_o) bad = 1'b1;
        end
        check("no write after reset", 32'(bad), 32'd0);

        // Read aborted before issue: a write is in flight, the read is forgotten.
        do_reset();
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h400; s_data_i = 32'h55;
        tick();
        s_we_i = 1'b0; s_addr_i = 32'h404;
        tick();
        tick();
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        tick();
        m_ack_i = 1'b1;
        tick();
        m_ack_i = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (m_cyc_o || s_ack_o) bad = 1'b1;
        end
        check("abort before issue", 32'(bad), 32'd0);

        // Read aborted after issue: completes on the master side, data dropped.
        sd_hold = s_data_o;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h500;
        wait_mcyc(10, seen);
        check("issued read seen", 32'(seen), 32'd1);
        check("issued read we", 32'(m_we_o), 32'd0);
        check("issued read addr", m_addr_o, 32'h500);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        tick();
        m_data_i = 32'h0BAD_0BAD; m_ack_i = 1'b1;
        tick();
        m_ack_i = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (s_ack_o) bad = 1'b1;
        end
        check("abort after issue ack", 32'(bad), 32'd0);
        check("abort after issue data", s_data_o, sd_hold);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
